// File: rtl/controlador_sinal_if.sv
// Command/indication bundle between game logic and the blink controller.
interface controlador_sinal_if #(
    parameter int unsigned NUM_W = 3
) ();
    logic             start;
    logic             stop;
    logic [NUM_W-1:0] num_blinks;
    logic             sig_out;
    logic             busy;
    logic             done;

    // Game logic side: issues commands, observes status.
    modport master (
        output start, stop, num_blinks,
        input  sig_out, busy, done
    );

    // Controller side: accepts commands, drives pin and status.
    modport slave (
        input  start, stop, num_blinks,
        output sig_out, busy, done
    );
endinterface

// File: rtl/controlador_sinal.sv
// Blink controller: a one-cycle start pulse produces N timed activations of an
// LED/buzzer pin, with busy while running and a one-cycle done at the end.
module controlador_sinal #(
    parameter int unsigned ON_TICKS   = 255,
    parameter int unsigned OFF_TICKS  = 255,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned NUM_W      = 3,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    controlador_sinal_if.slave bus
);

    localparam logic [CNT_W-1:0] OnLast    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OffLast   = CNT_W'(OFF_TICKS - 1);
    localparam logic             SigActive = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic             SigIdle   = ~SigActive;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [NUM_W-1:0] remaining_q, remaining_d;
    logic             sig_out_q, sig_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state logic; outputs are derived from the next state so they are
    // registered yet aligned with the state they describe.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // stop has priority over a simultaneous start
                if (bus.start && !bus.stop) begin
                    if (bus.num_blinks != '0) begin
                        remaining_d = bus.num_blinks;
                        tick_d      = '0;
                        state_d     = StOn;
                    end else begin
                        // zero-length pattern completes immediately
                        done_d = 1'b1;
                    end
                end
            end
            StOn: begin
                if (bus.stop) begin
                    state_d     = StIdle;
                    tick_d      = '0;
                    remaining_d = '0;
                end else if (tick_q == OnLast) begin
                    tick_d      = '0;
                    remaining_d = remaining_q - NUM_W'(1);
                    if (remaining_q == NUM_W'(1)) begin
                        // last blink: no trailing off period
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StOff;
                    end
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            StOff: begin
                if (bus.stop) begin
                    state_d     = StIdle;
                    tick_d      = '0;
                    remaining_d = '0;
                end else if (tick_q == OffLast) begin
                    tick_d  = '0;
                    state_d = StOn;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = StIdle;
                tick_d      = '0;
                remaining_d = '0;
            end
        endcase

        sig_out_d = (state_d == StOn) ? SigActive : SigIdle;
        busy_d    = (state_d != StIdle);
    end

    // State and output registers; reset forces the pin inactive at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            remaining_q <= '0;
            sig_out_q   <= SigIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            remaining_q <= remaining_d;
            sig_out_q   <= sig_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.sig_out = sig_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
